hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5, sets the busy cycles of a mult/multu after it leaves E; legal range is 1 or more.
REQ-002 Parameter DIV_CYCLES, default 10, sets the busy cycles of a div/divu after it leaves E; it SHALL be at least MULT_CYCLES.
REQ-003 Parameter TW, default 2, sets the width of the Tuse/Tnew fields; the all-ones value means "operand unused".
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 d_rs, d_rt  in  5 each  source register numbers of the instruction in D.
REQ-007 d_tuse_rs, d_tuse_rt  in  TW each  cycles until D needs the operand (0 means needed in D).
REQ-008 d_regwrite  in  1  the instruction in D writes the GPR file.
REQ-009 d_dst  in  5  destination register of the instruction in D.
REQ-010 d_tnew  in  TW  result-ready delay counted from E entry (load 2, ALU/mf* 1, jal 0).
REQ-011 d_mdu_use  in  1  the instruction in D is mult/div/mfhi/mflo/mthi/mtlo.
REQ-012 d_start  in  1  the instruction in D starts the MDU.
REQ-013 d_is_div  in  1  qualifies d_start: 1 selects div/divu timing.
REQ-014 flush  in  1  synchronous exception/eret flush of E and M.
REQ-015 stall  out  1  freezes PC and the F/D register, and injects a bubble into E.
REQ-016 fwd_rs_sel, fwd_rt_sel  out  2 each  D-stage operand source: 0 = RF, 1 = E, 2 = M, 3 = W.
REQ-017 mdu_busy  out  1  the MDU is occupied.

Function
REQ-018 Three tracking slots SHALL be kept: E, M and W, each holding {valid, dst, tnew}.
REQ-019 A slot SHALL count as a producer only if valid=1, its write is enabled and dst is not 0.
REQ-020 On an edge with stall=0 and flush=0, E SHALL load {d_regwrite, d_dst, d_tnew}.
REQ-021 On an edge with stall=1, E SHALL become invalid (bubble).
REQ-022 On every edge, M SHALL take E with tnew decremented, saturating at 0.
REQ-023 On every edge, W SHALL take M with tnew forced to 0.
REQ-024 On an edge with flush=1, E and M SHALL become invalid, and W SHALL take the old M unchanged.
REQ-025 Hazard rule per operand: find the youngest matching producer, searching E, then M, then W.
REQ-026 For that producer: tnew > tuse SHALL raise stall; tnew = 0 SHALL set the fwd sel to that stage; otherwise the fwd sel SHALL be 0.
REQ-027 An operand with source register 0, or with tuse equal to all-ones, SHALL never stall and SHALL read 0 on fwd.
REQ-028 An older producer SHALL never be selected when a younger one matches.
REQ-029 An E flag e_start/e_div SHALL load d_start/d_is_div under the same advance rule as E, and SHALL clear on stall or flush.
REQ-030 The MDU counter SHALL be $clog2(DIV_CYCLES+1) bits wide.
REQ-031 On an edge with e_start=1 and flush=0, the counter SHALL load DIV_CYCLES if e_div, else MULT_CYCLES.
REQ-032 Otherwise the counter SHALL decrement while nonzero and hold at 0.
REQ-033 mdu_busy SHALL equal e_start OR (counter not 0), as a combinational output.
REQ-034 stall SHALL also assert when d_mdu_use and mdu_busy are both 1.
REQ-035 stall SHALL be the OR of the rs, rt and MDU conditions.
REQ-036 flush SHALL NOT abort a counter already loaded; that operation runs to completion.
REQ-037 stall and flush asserted together: flush SHALL take priority for E and e_start, both cleared.

Reset
REQ-038 While reset=1, all slots SHALL be invalid, e_start=0 and the counter=0.
REQ-039 During reset, stall=0, mdu_busy=0 and both fwd sels=0 for any D inputs.
REQ-040 Reset asserted mid-divide SHALL clear mdu_busy immediately, without waiting for a clock edge.

Verification
REQ-041 Load-use: lw $1 in E (tnew 2), D add reading rs=$1 with tuse 1 -> stall=1 for exactly 1 cycle, then stall=0 with lw in M (tnew 1).
REQ-042 Branch: addu $2 in E (tnew 1), D beq rs=$2 with tuse 0 -> stall=1 for 1 cycle, then fwd_rs_sel=2 with stall=0.
REQ-043 MDU: with MULT_CYCLES=5, mult in D at cycle 0 and mfhi behind it -> mdu_busy=1 in cycles 1..6, stall=1 in cycles 1..6, mfhi advances in cycle 7.
REQ-044 A matching $0 producer with tnew 2 and D tuse 0 -> stall=0 and fwd sel=0.
REQ-045 Flush: lw $3 in E, flush=1 at the edge, D reads $3 with tuse 0 next cycle -> stall=0 and fwd_rs_sel=0.
REQ-046 Reset asserted while the div counter is 7 -> mdu_busy=0 in the same cycle, and counter=0 after release.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard detection and forwarding control for a 5-stage MIPS-style pipeline.
// Tracks E/M/W producers with Tnew and compares them against D-stage Tuse, plus the MDU busy window.
module hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned TW          = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [4:0]    d_rs,
  input  logic [4:0]    d_rt,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic          d_regwrite,
  input  logic [4:0]    d_dst,
  input  logic [TW-1:0] d_tnew,
  input  logic          d_mdu_use,
  input  logic          d_start,
  input  logic          d_is_div,
  input  logic          flush,
  output logic          stall,
  output logic [1:0]    fwd_rs_sel,
  output logic [1:0]    fwd_rt_sel,
  output logic          mdu_busy
);

  localparam int unsigned CW = $clog2(DIV_CYCLES + 1);
  localparam int unsigned NS = 3;

  logic          e_valid_q, e_valid_d;
  logic [4:0]    e_dst_q,   e_dst_d;
  logic [TW-1:0] e_tnew_q,  e_tnew_d;
  logic          m_valid_q, m_valid_d;
  logic [4:0]    m_dst_q,   m_dst_d;
  logic [TW-1:0] m_tnew_q,  m_tnew_d;
  logic          w_valid_q, w_valid_d;
  logic [4:0]    w_dst_q,   w_dst_d;
  logic [TW-1:0] w_tnew_q,  w_tnew_d;
  logic          e_start_q, e_start_d;
  logic          e_div_q,   e_div_d;
  logic [CW-1:0] cnt_q,     cnt_d;

  logic [NS-1:0]         prod_v;
  logic [NS-1:0][4:0]    prod_dst;
  logic [NS-1:0][TW-1:0] prod_tnew;
  logic [2:0]            rs_res;
  logic [2:0]            rt_res;
  logic                  busy_raw;
  logic                  stall_raw;
  logic                  advance;

  // Returns {stall, fwd_sel} for one operand; the youngest matching producer decides.
  function automatic logic [2:0] resolve(
    input logic [4:0]            src,
    input logic [TW-1:0]         tuse,
    input logic [NS-1:0]         pv,
    input logic [NS-1:0][4:0]    pd,
    input logic [NS-1:0][TW-1:0] pt
  );
    logic [2:0]    r;
    logic [TW-1:0] tn;
    logic [1:0]    sel;
    logic          hit;
    r   = 3'b000;
    tn  = '0;
    sel = 2'd0;
    hit = 1'b0;
    if (pv[0] && (pd[0] == src)) begin
      hit = 1'b1;
      tn  = pt[0];
      sel = 2'd1;
    end else if (pv[1] && (pd[1] == src)) begin
      hit = 1'b1;
      tn  = pt[1];
      sel = 2'd2;
    end else if (pv[2] && (pd[2] == src)) begin
      hit = 1'b1;
      tn  = pt[2];
      sel = 2'd3;
    end
    if ((src != 5'd0) && (tuse != '1) && hit) begin
      if (tn > tuse) begin
        r[2] = 1'b1;
      end else if (tn == '0) begin
        r[1:0] = sel;
      end
    end
    return r;
  endfunction

  assign prod_v    = {w_valid_q & (w_dst_q != 5'd0),
                      m_valid_q & (m_dst_q != 5'd0),
                      e_valid_q & (e_dst_q != 5'd0)};
  assign prod_dst  = {w_dst_q, m_dst_q, e_dst_q};
  assign prod_tnew = {w_tnew_q, m_tnew_q, e_tnew_q};

  assign rs_res = resolve(d_rs, d_tuse_rs, prod_v, prod_dst, prod_tnew);
  assign rt_res = resolve(d_rt, d_tuse_rt, prod_v, prod_dst, prod_tnew);

  assign busy_raw  = e_start_q | (cnt_q != '0);
  assign stall_raw = rs_res[2] | rt_res[2] | (d_mdu_use & busy_raw);
  assign advance   = ~stall_raw & ~flush;

  // Outputs are forced quiet while reset is held, independent of any clock edge.
  assign stall      = ~reset & stall_raw;
  assign fwd_rs_sel = reset ? 2'd0 : rs_res[1:0];
  assign fwd_rt_sel = reset ? 2'd0 : rt_res[1:0];
  assign mdu_busy   = ~reset & busy_raw;

  // Next-state for the tracking slots and the MDU counter.
  always_comb begin
    e_valid_d = 1'b0;
    e_dst_d   = d_dst;
    e_tnew_d  = d_tnew;
    e_start_d = 1'b0;
    e_div_d   = 1'b0;
    m_valid_d = e_valid_q;
    m_dst_d   = e_dst_q;
    m_tnew_d  = (e_tnew_q == '0) ? '0 : e_tnew_q - TW'(1);
    w_valid_d = m_valid_q;
    w_dst_d   = m_dst_q;
    w_tnew_d  = '0;
    cnt_d     = (cnt_q == '0) ? '0 : cnt_q - CW'(1);

    if (advance) begin
      e_valid_d = d_regwrite;
      e_start_d = d_start;
      e_div_d   = d_is_div;
    end
    if (flush) begin
      m_valid_d = 1'b0;
      w_tnew_d  = m_tnew_q;
    end
    // A started op that leaves E unflushed owns the MDU; flush never aborts a loaded count.
    if (e_start_q && !flush) begin
      cnt_d = e_div_q ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_valid_q <= 1'b0;
      e_dst_q   <= 5'd0;
      e_tnew_q  <= '0;
      m_valid_q <= 1'b0;
      m_dst_q   <= 5'd0;
      m_tnew_q  <= '0;
      w_valid_q <= 1'b0;
      w_dst_q   <= 5'd0;
      w_tnew_q  <= '0;
      e_start_q <= 1'b0;
      e_div_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      e_valid_q <= e_valid_d;
      e_dst_q   <= e_dst_d;
      e_tnew_q  <= e_tnew_d;
      m_valid_q <= m_valid_d;
      m_dst_q   <= m_dst_d;
      m_tnew_q  <= m_tnew_d;
      w_valid_q <= w_valid_d;
      w_dst_q   <= w_dst_d;
      w_tnew_q  <= w_tnew_d;
      e_start_q <= e_start_d;
      e_div_q   <= e_div_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule
